// File: rtl/uart_rx.sv
// uart_rx: oversampled asynchronous serial receiver, LSB first, no parity.
// Start bit is qualified at its midpoint; every later bit (data and stop)
// is sampled once at mid-bit, OVERSAMPLE os_ticks after the previous sample.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 os_tick,
    input  logic                 rx_line,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t                 state;
    logic                   rx_m;
    logic                   rx_s;
    logic [TW-1:0]          tick_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shift_reg;

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_line;
            rx_s <= rx_m;
        end
    end

    // Frame FSM: all timing advances on os_tick; valid/frame_err are one-cycle pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (os_tick) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state    <= START;
                            tick_cnt <= '0;
                            busy     <= 1'b1;
                        end
                    end
                    START: begin
                        if (tick_cnt == TICK_MID) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            if (rx_s) begin
                                // Glitch rather than a real start bit
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= DATA;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt  <= '0;
                            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                            if (bit_cnt == BIT_LAST) begin
                                state <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            busy     <= 1'b0;
                            if (rx_s) begin
                                data_out <= shift_reg;
                                valid    <= 1'b1;
                                state    <= IDLE;
                            end else begin
                                // Broken frame: keep the last good byte, wait for the line to recover
                                frame_err <= 1'b1;
                                state     <= WAIT_HIGH;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    WAIT_HIGH: begin
                        if (rx_s) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. Stimulus pushes the expected
// outcome of each frame into a queue; an independent monitor pops and
// compares on every valid/frame_err pulse.
module tb_uart_rx;

    localparam int OS = 16;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       os_tick;
    logic       rx_line;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       busy;

    exp_t       sb[$];
    logic [7:0] model_last;
    logic       stall;
    int         n_tests;
    int         n_fail;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .os_tick   (os_tick),
        .rx_line   (rx_line),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // os_tick every 4th clk, suppressed while stall is set
    initial begin
        int div;
        div     = 0;
        os_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (stall) begin
                os_tick = 1'b0;
            end else begin
                div     = (div + 1) % 4;
                os_tick = (div == 0);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (!os_tick);
        end
    endtask

    task automatic set_line(input logic b, input int n);
        @(negedge clk);
        rx_line = b;
        wait_ticks(n);
    endtask

    // One full frame; stall_bit >= 0 freezes os_tick for 100 clks inside that data bit
    task automatic send_frame(input logic [7:0] d, input logic stop, input int stall_bit);
        exp_t e;
        e.err  = ~stop;
        e.data = stop ? d : model_last;
        if (stop) model_last = d;
        sb.push_back(e);
        set_line(1'b0, OS);
        for (int i = 0; i < 8; i++) begin
            if (i == stall_bit) begin
                set_line(d[i], OS / 2 - 3);
                @(negedge clk);
                stall = 1'b1;
                repeat (100) @(negedge clk);
                check("stall_busy_held", {31'd0, busy}, 32'd1);
                stall = 1'b0;
                wait_ticks(OS / 2 + 3);
            end else begin
                set_line(d[i], OS);
            end
        end
        set_line(stop, OS);
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        logic prev_pulse;
        prev_pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (valid || frame_err) begin
                check("pulse_exclusive", {31'd0, valid & frame_err}, 32'd0);
                check("pulse_width", {31'd0, prev_pulse}, 32'd0);
                check("busy_at_pulse", {31'd0, busy}, 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {30'd0, valid, frame_err}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("pulse_kind_err", {31'd0, frame_err}, {31'd0, e.err});
                    check("data_out", {24'd0, data_out}, {24'd0, e.data});
                end
            end
            prev_pulse = valid | frame_err;
        end
    end

    initial begin
        int   gap;
        logic stp;
        logic [7:0] d;
        n_tests    = 0;
        n_fail     = 0;
        stall      = 1'b0;
        model_last = 8'h00;
        rx_line    = 1'b1;
        rst_n      = 1'b0;
        #1;
        check("reset_data_out", {24'd0, data_out}, 32'd0);
        check("reset_flags", {29'd0, valid, frame_err, busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        set_line(1'b1, 4);

        // Single good frame
        send_frame(8'hA5, 1'b1, -1);
        set_line(1'b1, 2 * OS);
        check("a5_received", sb.size(), 32'd0);
        check("a5_data_held", {24'd0, data_out}, 32'hA5);
        check("a5_busy_low", {31'd0, busy}, 32'd0);

        // False start: 4 ticks low
        set_line(1'b0, 4);
        @(negedge clk);
        check("false_start_busy", {31'd0, busy}, 32'd1);
        set_line(1'b1, OS);
        check("false_start_idle", {31'd0, busy}, 32'd0);

        // Stop bit low, line held low, then released
        send_frame(8'h00, 1'b0, -1);
        set_line(1'b0, 20);
        check("wait_high_not_busy", {31'd0, busy}, 32'd0);
        check("ferr_data_kept", {24'd0, data_out}, 32'hA5);
        set_line(1'b0, 20);
        check("wait_high_no_frame", {31'd0, busy}, 32'd0);
        set_line(1'b1, 2 * OS);
        check("ferr_seen", sb.size(), 32'd0);

        // Back-to-back frames
        send_frame(8'h55, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        set_line(1'b1, 2 * OS);
        check("b2b_received", sb.size(), 32'd0);
        check("b2b_last_data", {24'd0, data_out}, 32'hFF);

        // Reset during data bit 3
        set_line(1'b0, OS);
        set_line(1'b0, OS);
        set_line(1'b1, OS);
        set_line(1'b1, OS);
        set_line(1'b0, OS / 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_data_out", {24'd0, data_out}, 32'd0);
        check("midreset_flags", {29'd0, valid, frame_err, busy}, 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        rx_line    = 1'b1;
        model_last = 8'h00;
        set_line(1'b1, 2 * OS);
        send_frame(8'h3C, 1'b1, -1);
        set_line(1'b1, OS);
        check("post_reset_frame", {24'd0, data_out}, 32'h3C);

        // Stall in the middle of data
        send_frame(8'hC3, 1'b1, 3);
        set_line(1'b1, OS);
        check("stall_frame", {24'd0, data_out}, 32'hC3);

        // Randomized frames
        for (int k = 0; k < 20; k++) begin
            d   = 8'($urandom);
            stp = ($urandom_range(0, 4) != 0);
            send_frame(d, stp, -1);
            gap = stp ? int'($urandom_range(0, 20)) : int'($urandom_range(2, 20));
            if (gap > 0) set_line(1'b1, gap);
        end
        set_line(1'b1, 2 * OS);
        check("all_expected_seen", sb.size(), 32'd0);
        check("final_busy_low", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
